// File: rtl/fantasticfft_fft8_loader_if.sv
// Sample-in / frame-out bus of the FFT8 loader.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid is never gated by ready, and payload is held stable
// while valid is high and the transfer has not yet happened.
interface fantasticfft_fft8_loader_if #(
    parameter int W = 16,
    parameter int N = 8
);
    logic           s_valid;
    logic           s_ready;
    logic           s_first;
    logic [W-1:0]   s_re;
    logic [W-1:0]   s_im;
    logic           frame_valid;
    logic           frame_ready;
    logic [N*W-1:0] frame_re;
    logic [N*W-1:0] frame_im;
    logic           frame_err;

    // Loader side: consumes samples, produces frames.
    modport slave (
        input  s_valid, s_first, s_re, s_im, frame_ready,
        output s_ready, frame_valid, frame_re, frame_im, frame_err
    );

    // Environment side: produces samples, consumes frames.
    modport master (
        output s_valid, s_first, s_re, s_im, frame_ready,
        input  s_ready, frame_valid, frame_re, frame_im, frame_err
    );
endinterface

// File: rtl/fantasticfft_fft8_loader.sv
// FFT8 input loader: assembles 8 complex samples into a ping-pong frame
// buffer at bit-reversed slots and hands full frames to the FFT core.
// Optional feature macro: FANTASTICFFT_LOADER_SCALE_EN pre-scales each
// component by 1/8 with round-half-up ((x + 4) >>> 3, no saturation).
module fantasticfft_fft8_loader #(
    parameter int W = 16,
    parameter int N = 8
) (
    input logic clk,
    input logic rst,
    fantasticfft_fft8_loader_if.slave bus
);

    // The slot addressing below is hard-wired for 8-point frames.
    if (N != 8) begin : g_bad_n
        $fatal(1, "fantasticfft_fft8_loader: N must be 8");
    end

    logic [W-1:0] re_q [2][8];
    logic [W-1:0] im_q [2][8];
    logic [1:0]   full_q, full_d;
    logic         wr_bank_q, wr_bank_d;
    logic         rd_bank_q, rd_bank_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         err_q, err_d;

    logic         accept;
    logic         fire;
    logic [2:0]   idx;
    logic [2:0]   slot;
    logic [W-1:0] wr_re;
    logic [W-1:0] wr_im;

`ifdef FANTASTICFFT_LOADER_SCALE_EN
    localparam logic [W:0] RND = (W+1)'(4);

    // Divide by 8 with rounding, computed one bit wider so the +4 cannot wrap.
    function automatic logic [W-1:0] prescale(input logic [W-1:0] x);
        logic signed [W:0] ext;
        ext = $signed({x[W-1], x}) + $signed(RND);
        return W'(ext >>> 3);
    endfunction

    assign wr_re = prescale(bus.s_re);
    assign wr_im = prescale(bus.s_im);
`else
    assign wr_re = bus.s_re;
    assign wr_im = bus.s_im;
`endif

    // Ready depends only on registered state so it never combinationally
    // follows frame_ready.
    assign bus.s_ready     = !full_q[wr_bank_q] && !rst;
    assign bus.frame_valid = full_q[rd_bank_q];
    assign bus.frame_err   = err_q;

    assign accept = bus.s_valid && bus.s_ready;
    assign fire   = full_q[rd_bank_q] && bus.frame_ready;
    assign idx    = bus.s_first ? 3'd0 : cnt_q;
    assign slot   = {idx[0], idx[1], idx[2]};

    // Next-state for bank flags, pointers, sample counter and error pulse.
    // Fill and drain never touch the same bank in one cycle: an accept needs
    // the write bank empty, a frame handshake needs the read bank full.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        if (accept) begin
            err_d = bus.s_first && (cnt_q != 3'd0);
            if (idx == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                cnt_d             = 3'd0;
            end else begin
                cnt_d = idx + 3'd1;
            end
        end
        if (fire) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            cnt_q     <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Frame storage: reset clears both banks, accepts write one slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) begin
                    re_q[b][k] <= '0;
                    im_q[b][k] <= '0;
                end
            end
        end else if (accept) begin
            re_q[wr_bank_q][slot] <= wr_re;
            im_q[wr_bank_q][slot] <= wr_im;
        end
    end

    // Present the read bank as flat vectors, slot k at [k*W +: W].
    always_comb begin
        bus.frame_re = '0;
        bus.frame_im = '0;
        for (int k = 0; k < 8; k++) begin
            bus.frame_re[k*W +: W] = re_q[rd_bank_q][k];
            bus.frame_im[k*W +: W] = im_q[rd_bank_q][k];
        end
    end

endmodule

// File: doc/fantasticfft_fft8_loader.md
# fantasticfft_fft8_loader

Input framing stage directly upstream of the 8-point FFT core. Accepts a stream of complex Q8.8 samples, assembles groups of 8 into a ping-pong frame buffer, and stores each sample at its bit-reversed slot. Completed frames are presented in parallel to the FFT core over a valid/ready handshake. One bank fills while the other waits for the core, so the input sustains one sample per cycle.

## Interface
- `W`, 16: sample component width, two's-complement Q(W/2).(W/2); Q8.8 at default.
- `N`, 8: frame length; fixed at 8. Any other value is a `$fatal` at elaboration.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  loader can accept a sample this cycle.
- `s_first`  in  1  qualifies sample as index 0 of a new frame; sampled only when `s_valid`.
- `s_re`, `s_im`  in  W  real/imag sample.
- `frame_valid`  out  1  full frame presented to FFT.
- `frame_ready`  in  1  FFT core consumes frame.
- `frame_re`, `frame_im`  out  N*W  slot k at bits [k*W +: W].
- `frame_err`  out  1  one-cycle pulse when a partial frame is discarded.

## Operation
- State: two banks (0/1) of N complex words, `full[1:0]`, `wr_bank`, `rd_bank`, 3-bit `cnt`.
- Accept = `s_valid & s_ready`; `s_ready = !full[wr_bank] & !rst`, registered state only, no path from `frame_ready`.
- On accept: sample stored at slot `bitrev3(idx)` of `wr_bank`, where `idx` = 0 if `s_first`, else `cnt`. Examples: idx 1 -> slot 4, idx 3 -> slot 6, idx 6 -> slot 3.
- `s_first` with `cnt != 0`: partial frame discarded, sample taken as index 0 of the same bank, `frame_err` pulses next cycle. `s_first` with `cnt == 0`: normal.
- When the accepted sample has idx 7: `full[wr_bank]` set, `wr_bank` toggles, `cnt` returns to 0. Otherwise `cnt = idx + 1`.
- `frame_valid = full[rd_bank]`; `frame_re`/`frame_im` drive bank `rd_bank`.
- On `frame_valid & frame_ready`: `full[rd_bank]` cleared, `rd_bank` toggles.
- Frame contents stay stable while `frame_valid` is high and unaccepted.
- No rounding or saturation; samples are stored bit-exact, except under Configuration.

## Timing
- Reset (cycle with `rst` high and the following state): `full=0`, `wr_bank=rd_bank=0`, `cnt=0`, `frame_valid=0`, `frame_err=0`, `frame_re=frame_im=0` (banks cleared), `s_ready=0` during reset and 1 on the first cycle after.
- Reset mid-frame or with a frame pending discards all data. No `frame_err` is generated by reset.
- Latency: `frame_valid` rises on the cycle after the idx-7 accept.
- Throughput: continuous 1 sample/cycle while the FFT accepts each frame within 8 cycles.
- Both banks full: `s_ready=0` until a frame handshake. `s_ready` reasserts the cycle after the handshake.
- Simultaneous idx-7 accept and frame handshake on the other bank: both updates take effect in the same edge, and `frame_valid` stays high for the new frame.
- `frame_err` is registered, exactly 1 cycle per discard.

## Configuration
- `FANTASTICFFT_LOADER_SCALE_EN` defined: each component is pre-scaled by 1/8 before storage to prevent FFT growth overflow.
  - Computed in W+1 bits as `(x + 4) >>> 3`, then truncated to W. Result is never saturated.
  - Examples: 0x0100 -> 0x0020; 0x7FFF -> 0x1000; 0x8000 -> 0xF000; 0xFFFC -> 0x0000.
- Undefined: bit-exact storage; no adder present.

## Test plan
- Reset, then stream re=0x0000..0x0700 step 0x0100 (im=-re), `s_first` on idx 0, `frame_ready=1` -> `frame_valid` one cycle after the 8th accept. Slots 0..7 re = 0x0000,0x0400,0x0200,0x0600,0x0100,0x0500,0x0300,0x0700.
- Hold `frame_ready=0`, stream 24 samples -> `s_ready` drops after the 16th accept, and frame 1 data stays stable. Raise `frame_ready` for 1 cycle -> frame 2 presented, `s_ready`=1 the next cycle.
- Continuous 64-sample stream with `frame_ready=1` -> 8 frames, zero stall cycles, each slot correct.
- `s_first` at idx 5 -> `frame_err` single pulse, and the next frame contains only samples from the new `s_first` onward.
- `rst` asserted after 4 samples with a frame pending -> all outputs 0. The next 8 samples form a correct frame in bank 0, and `frame_err` stays 0.
- With `FANTASTICFFT_LOADER_SCALE_EN`, inputs 0x7FFF, 0x8000, 0x0100, 0xFFFC -> stored 0x1000, 0xF000, 0x0020, 0x0000. Without the macro, the same inputs are stored unchanged.
